// File: rtl/finalsoc_pio_pkg.sv
// Shared constants for the finalsoc PIO blocks: register word addresses,
// edge-select encodings and the debounce counter width.
package finalsoc_pio_pkg;

  // Avalon word addresses of the input PIO register map (address 1 is unused)
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE encodings: which transition of the filtered input sets a capture bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit debounce counter width (holds DEBOUNCE_CYCLES up to 65535)
  localparam int DEBOUNCE_CNT_W = 16;

endpackage

// File: rtl/finalsoc_key_pio_if.sv
// Avalon-MM slave bus bundle for the finalsoc input PIO.
//
// Handshake: there is no waitrequest, so the slave is always ready. A write
// transfer is chipselect=1 with write_n=0 sampled on a rising clk edge; a read
// transfer is chipselect=1 with read_n=0 sampled on a rising clk edge, and
// readdata carries the result from that edge onward (fixed latency 1) and
// holds until the next read.
interface finalsoc_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/finalsoc_pio_debounce.sv
// Single-bit input conditioner: 2-FF synchronizer followed, when the
// FINALSOC_KEY_PIO_DEBOUNCE_EN macro is defined, by a stable-count debounce
// filter. Without the macro the output is the synchronized bit.
module finalsoc_pio_debounce
  import finalsoc_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync_1;
  logic sync_2;

  // Two-stage synchronizer for the asynchronous external input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= d;
      sync_2 <= sync_1;
    end
  end

`ifdef FINALSOC_KEY_PIO_DEBOUNCE_EN
  localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DEBOUNCE_CNT_W-1:0] cnt;
  logic                      filt;

  // Accept a new level only after it has disagreed with filt for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_2 != filt) begin
      if (cnt == CNT_LAST) begin
        filt <= sync_2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign q = filt;
`else
  // Debounce length has no meaning when the filter is not built
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;

  assign q = sync_2;
`endif

endmodule

// File: rtl/finalsoc_key_pio.sv
// finalsoc input PIO: Avalon-MM slave with synchronized (optionally debounced)
// inputs, sticky edge-capture register, interrupt mask and level IRQ.
// Optional debounce filter: define FINALSOC_KEY_PIO_DEBOUNCE_EN.
module finalsoc_key_pio
  import finalsoc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  finalsoc_key_pio_if.slave  bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;

  // Upper writedata bits beyond WIDTH are architecturally ignored
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_in
    finalsoc_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port[i]),
      .q       (filt[i])
    );
  end

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign rd_en    = bus.chipselect & ~bus.read_n;
  assign clr_bits = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

  // Select which transitions of filt count as capture events
  always_comb begin
    edge_hit = filt & ~filt_d;
    case (EDGE_TYPE)
      EDGE_RISE: edge_hit = filt & ~filt_d;
      EDGE_FALL: edge_hit = ~filt & filt_d;
      EDGE_ANY:  edge_hit = filt ^ filt_d;
      default:   edge_hit = filt & ~filt_d;
    endcase
  end

  // Read mux: addressed register zero-extended to the 32-bit bus
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = filt;
      ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = capture;
      default:   rd_mux = '0;
    endcase
  end

  // Edge history, sticky capture (a new edge beats a same-cycle clear), mask and IRQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d  <= '0;
      capture <= '0;
      mask    <= '0;
      irq     <= 1'b0;
    end else begin
      filt_d  <= filt;
      capture <= (capture & ~clr_bits) | edge_hit;
      if (wr_en && (bus.address == ADDR_MASK)) begin
        mask <= bus.writedata[WIDTH-1:0];
      end
      irq <= |(capture & mask);
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else if (rd_en) begin
      bus.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_finalsoc_key_pio.sv
// Bench for finalsoc_key_pio: directed steps plus randomized bus/input traffic
// checked against a history-based reference model of the PIO register map.
module tb_finalsoc_key_pio;
  import finalsoc_pio_pkg::*;

  localparam int WIDTH    = 4;
  localparam int EDGE_SEL = EDGE_RISE;
  localparam int DEB      = 16;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  finalsoc_key_pio_if bus();

  finalsoc_key_pio #(
    .WIDTH           (WIDTH),
    .EDGE_TYPE       (EDGE_SEL),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: samp[i] is the in_port value seen at the (i+1)-th clock
  // edge since reset release; the filtered input trails the pins by two edges.
  logic [WIDTH-1:0] samp[$];
  logic [WIDTH-1:0] m_mask = '0;
  logic [WIDTH-1:0] m_cap  = '0;
  logic             m_irq  = 1'b0;
  logic [31:0]      m_rd   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Filtered input value after k edges since reset release
  function automatic logic [WIDTH-1:0] filt_after(input int k);
    if (k >= 2) return samp[k-2];
    return '0;
  endfunction

  // Bits whose transition from prev_v to now_v matches the configured edge kind
  function automatic logic [WIDTH-1:0] sel_edges(input logic [WIDTH-1:0] now_v,
                                                 input logic [WIDTH-1:0] prev_v);
    logic [WIDTH-1:0] r;
    bit up, down;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      up   = (prev_v[b] == 1'b0) && (now_v[b] == 1'b1);
      down = (prev_v[b] == 1'b1) && (now_v[b] == 1'b0);
      if (EDGE_SEL == EDGE_FALL)     r[b] = down;
      else if (EDGE_SEL == EDGE_ANY) r[b] = up || down;
      else                           r[b] = up;
    end
    return r;
  endfunction

  // Driver: one clock cycle; op 0 idle, 1 read, 2 write
  task automatic step(input logic [WIDTH-1:0] din, input int op,
                      input logic [1:0] a, input logic [31:0] wd);
    logic [WIDTH-1:0] f_now, f_prev, hits, clr;
    logic             irq_next;
    int               k;
    in_port        = din;
    bus.chipselect = (op != 0);
    bus.read_n     = (op != 1);
    bus.write_n    = (op != 2);
    bus.address    = a;
    bus.writedata  = wd;
    @(posedge clk);
    k        = samp.size();
    f_now    = filt_after(k);
    f_prev   = filt_after(k - 1);
    hits     = sel_edges(f_now, f_prev);
    clr      = (op == 2 && a == 2'd3) ? wd[WIDTH-1:0] : '0;
    irq_next = (m_cap & m_mask) != '0;
    if (op == 1) begin
      m_rd = '0;
      if (a == 2'd0)      m_rd[WIDTH-1:0] = f_now;
      else if (a == 2'd2) m_rd[WIDTH-1:0] = m_mask;
      else if (a == 2'd3) m_rd[WIDTH-1:0] = m_cap;
    end
    m_cap = (m_cap & ~clr) | hits;
    if (op == 2 && a == 2'd2) m_mask = wd[WIDTH-1:0];
    m_irq = irq_next;
    samp.push_back(din);
    #1;
`ifndef FINALSOC_KEY_PIO_DEBOUNCE_EN
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    check("model_readdata", bus.readdata, m_rd);
`endif
  endtask

  // Reset: assert away from the edge, check cleared outputs, release after cycles
  task automatic do_reset(input int cycles, input logic [WIDTH-1:0] din);
    reset_n        = 1'b0;
    in_port        = din;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    #2;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    in_port = '0;
    reset_n = 1'b1;
    samp.delete();
    m_mask = '0;
    m_cap  = '0;
    m_irq  = 1'b0;
    m_rd   = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] din;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    #1;
    do_reset(3, '0);

    // Reads right after reset return zero
    step('0, 1, 2'd0, 0); check("rst_rd_data", bus.readdata, 32'h0);
    step('0, 1, 2'd1, 0); check("rst_rd_addr1", bus.readdata, 32'h0);
    step('0, 1, 2'd2, 0); check("rst_rd_mask", bus.readdata, 32'h0);
    step('0, 1, 2'd3, 0); check("rst_rd_cap", bus.readdata, 32'h0);
    check("rst_irq_idle", {31'b0, irq}, 32'h0);

`ifndef FINALSOC_KEY_PIO_DEBOUNCE_EN
    // Rising edge on bit 1: capture after 3 edges, irq one cycle later
    step('0, 2, 2'd2, 32'hF);
    step(4'b0010, 0, 2'd0, 0);
    step(4'b0010, 0, 2'd0, 0);
    step(4'b0010, 0, 2'd0, 0);
    check("irq_before_cap", {31'b0, irq}, 32'h0);
    step(4'b0010, 1, 2'd3, 0);
    check("cap_latency", bus.readdata, 32'h2);
    check("irq_after_cap", {31'b0, irq}, 32'h1);
    step(4'b0010, 1, 2'd0, 0);
    check("rd_data_filt", bus.readdata, 32'h2);

    // Write-1 clear, irq drops one cycle later
    step(4'b0010, 2, 2'd3, 32'h2);
    step(4'b0010, 0, 2'd0, 0);
    check("irq_drop", {31'b0, irq}, 32'h0);

    // Edge on bit 0 coinciding with its clear: the edge wins
    step(4'b0011, 0, 2'd0, 0);
    step(4'b0011, 0, 2'd0, 0);
    step(4'b0011, 2, 2'd3, 32'h1);
    step(4'b0011, 1, 2'd3, 0);
    check("edge_beats_clear", bus.readdata, 32'h1);

    // Writing zero leaves capture untouched
    step(4'b0011, 2, 2'd3, 32'h0);
    step(4'b0011, 1, 2'd3, 0);
    check("wr0_no_effect", bus.readdata, 32'h1);

    // Masked capture on bit 3, then unmask
    step(4'b0011, 2, 2'd3, 32'hFFFF_FFFF);
    step(4'b0011, 2, 2'd2, 32'h0);
    step(4'b1011, 0, 2'd0, 0);
    step(4'b1011, 0, 2'd0, 0);
    step(4'b1011, 0, 2'd0, 0);
    step(4'b1011, 1, 2'd3, 0);
    check("masked_cap", bus.readdata, 32'h8);
    check("masked_irq", {31'b0, irq}, 32'h0);
    step(4'b1011, 2, 2'd2, 32'hFFFF_FFF8);
    check("unmask_irq_same", {31'b0, irq}, 32'h0);
    step(4'b1011, 1, 2'd2, 0);
    check("unmask_irq_next", {31'b0, irq}, 32'h1);
    check("mask_upper_ignored", bus.readdata, 32'h8);

    // Randomized traffic against the model
    din = 4'b1011;
    for (int n = 0; n < 400; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) din = WIDTH'($urandom);
      r = $urandom_range(0, 4);
      step(din, (r < 2) ? 0 : (r < 4) ? 1 : 2, 2'($urandom_range(0, 3)), $urandom);
    end

    // Reset in the middle of activity, then more random traffic
    do_reset(2, WIDTH'($urandom));
    for (int n = 0; n < 200; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) din = WIDTH'($urandom);
      r = $urandom_range(0, 4);
      step(din, (r < 2) ? 0 : (r < 4) ? 1 : 2, 2'($urandom_range(0, 3)), $urandom);
    end
`else
    // Debounce: a 10-cycle pulse never reaches filt
    step('0, 2, 2'd2, 32'hF);
    repeat (10) step(4'b0010, 0, 2'd0, 0);
    repeat (25) step(4'b0000, 0, 2'd0, 0);
    step('0, 1, 2'd3, 0);
    check("deb_glitch_blocked", bus.readdata, 32'h0);
    check("deb_glitch_irq", {31'b0, irq}, 32'h0);

    // A held level sets capture 19 edges after the change
    repeat (18) step(4'b0010, 0, 2'd0, 0);
    step(4'b0010, 1, 2'd3, 0);
    check("deb_cap_not_yet", bus.readdata, 32'h0);
    step(4'b0010, 1, 2'd3, 0);
    check("deb_cap_19", bus.readdata, 32'h2);
    check("deb_irq", {31'b0, irq}, 32'h1);
    step(4'b0010, 1, 2'd0, 0);
    check("deb_filt", bus.readdata, 32'h2);

    // Return low, then reset while a new rise is mid-count
    step(4'b0010, 2, 2'd3, 32'hF);
    repeat (20) step(4'b0000, 0, 2'd0, 0);
    repeat (8) step(4'b0010, 0, 2'd0, 0);
    do_reset(2, '0);
    step('0, 2, 2'd2, 32'hF);
    repeat (30) step(4'b0000, 0, 2'd0, 0);
    step('0, 1, 2'd3, 0);
    check("deb_rst_no_cap", bus.readdata, 32'h0);
    step('0, 1, 2'd0, 0);
    check("deb_rst_filt", bus.readdata, 32'h0);
    check("deb_rst_irq", {31'b0, irq}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
